// File: rtl/uart_cmd_responder_if.sv
// Byte-stream and register-bus signals of uart_cmd_responder.
// master: the responder (consumes Rx, produces Tx, drives the register bus).
// slave:  the environment (UART byte streams and the register bank).
interface uart_cmd_responder_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data_i;
  logic              rx_vld_i;
  logic              rx_rdy_o;
  logic [7:0]        tx_data_o;
  logic              tx_vld_o;
  logic              tx_rdy_i;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [7:0]        reg_wdata_o;
  logic              reg_we_o;
  logic              reg_re_o;
  logic [7:0]        reg_rdata_i;

  modport master (
    input  rx_data_i, rx_vld_i, tx_rdy_i, reg_rdata_i,
    output rx_rdy_o, tx_data_o, tx_vld_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o
  );

  modport slave (
    output rx_data_i, rx_vld_i, tx_rdy_i, reg_rdata_i,
    input  rx_rdy_o, tx_data_o, tx_vld_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses 'W' addr data / 'R' addr command frames from a
// UART Rx byte stream, performs one register access per frame and answers
// with one Tx byte (read data, 'K' or 'E').
// Optional feature macro: UART_CMD_CHKSUM_EN -- every frame carries a trailing
// XOR checksum byte that is verified in GET_CHK before the access.
// All outputs are registered; next values are computed from the next state.
module uart_cmd_responder #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  uart_cmd_responder_if.master  bus,
  output logic                  busy_o,
  output logic [7:0]            err_cnt_o
);

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CHK, S_EXEC, S_WAIT_RD, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_vld_q, tx_vld_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic rx_acc;
  logic in_get;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rx_acc = bus.rx_vld_i & rx_rdy_q;
  assign in_get = rx_rdy_q & (state_q != S_IDLE);

  // Next-state, frame capture, timeout and registered-output computation
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    err_cnt_d  = err_cnt_q;
    idle_cnt_d = idle_cnt_q;
`ifdef UART_CMD_CHKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          idle_cnt_d = '0;
`ifdef UART_CMD_CHKSUM_EN
          chk_d = bus.rx_data_i;
`endif
          if (bus.rx_data_i == OP_WR || bus.rx_data_i == OP_RD) begin
            is_wr_d = (bus.rx_data_i == OP_WR);
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d = RSP_ERR;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = S_RESP;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_acc) begin
          idle_cnt_d = '0;
          addr_d     = bus.rx_data_i[ADDR_W-1:0];
`ifdef UART_CMD_CHKSUM_EN
          chk_d   = chk_q ^ bus.rx_data_i;
          state_d = is_wr_q ? S_GET_DATA : S_GET_CHK;
`else
          state_d = is_wr_q ? S_GET_DATA : S_EXEC;
`endif
        end
      end
      S_GET_DATA: begin
        if (rx_acc) begin
          idle_cnt_d = '0;
          wdata_d    = bus.rx_data_i;
`ifdef UART_CMD_CHKSUM_EN
          chk_d   = chk_q ^ bus.rx_data_i;
          state_d = S_GET_CHK;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_GET_CHK: begin
`ifdef UART_CMD_CHKSUM_EN
        if (rx_acc) begin
          idle_cnt_d = '0;
          if (bus.rx_data_i == chk_q) begin
            state_d = S_EXEC;
          end else begin
            tx_data_d = RSP_ERR;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = S_RESP;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_EXEC: begin
        if (is_wr_q) begin
          tx_data_d = RSP_ACK;
          state_d   = S_RESP;
        end else begin
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        tx_data_d = bus.reg_rdata_i;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (tx_vld_q && bus.tx_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte accepted in the timeout cycle takes precedence over the abort.
    if (in_get && !rx_acc) begin
      if (idle_cnt_q == CNT_MAX) begin
        idle_cnt_d = '0;
        err_cnt_d  = sat_inc(err_cnt_q);
        state_d    = S_IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end

    rx_rdy_d = (state_d == S_IDLE) || (state_d == S_GET_ADDR) ||
               (state_d == S_GET_DATA) || (state_d == S_GET_CHK);
    tx_vld_d = (state_d == S_RESP);
    reg_we_d = (state_d == S_EXEC) && is_wr_d;
    reg_re_d = (state_d == S_EXEC) && !is_wr_d;
    busy_d   = (state_d != S_IDLE);
  end

  // FSM state and registered outputs; reset clears everything but rx_rdy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rx_rdy_q   <= 1'b1;
      reg_we_q   <= 1'b0;
      reg_re_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_cnt_q  <= '0;
      idle_cnt_q <= '0;
`ifdef UART_CMD_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rx_rdy_q   <= rx_rdy_d;
      reg_we_q   <= reg_we_d;
      reg_re_q   <= reg_re_d;
      busy_q     <= busy_d;
      err_cnt_q  <= err_cnt_d;
      idle_cnt_q <= idle_cnt_d;
`ifdef UART_CMD_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign bus.rx_rdy_o    = rx_rdy_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_vld_o    = tx_vld_q;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_we_o    = reg_we_q;
  assign bus.reg_re_o    = reg_re_q;
  assign busy_o          = busy_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder (TIMEOUT=16): a table of single
// frames with hand-computed responses, plus sequences for timeout, Tx
// back-pressure, reset mid-frame and error-counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge by a monitor and by the main sequence after the edge.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_cmd_responder_if #(.ADDR_W(8)) bus ();

  uart_cmd_responder #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: read data valid the cycle after the read strobe.
  logic [7:0] mem [256];
  logic [7:0] rdata_q = 8'h00;
  logic       mem_init = 1'b0;
  assign bus.reg_rdata_i = rdata_q;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h22] <= 8'h3C;
      mem_init   <= 1'b1;
    end else begin
      if (bus.reg_we_o) mem[bus.reg_addr_o] <= bus.reg_wdata_o;
      if (bus.reg_re_o) rdata_q <= mem[bus.reg_addr_o];
    end
  end

  // Monitor: strobes, Tx transfers and Tx stability while back-pressured.
  int         we_n = 0, re_n = 0, tx_n = 0, stab_bad = 0;
  int         we_cyc = 0, re_cyc = 0, tx_first = 0;
  logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, tx_last = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_data = 0;
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    if (pend && (!bus.tx_vld_o || bus.tx_data_o != pend_data)) stab_bad++;
    if (bus.tx_vld_o && !pend) tx_first = cyc;
    if (bus.tx_vld_o && bus.tx_rdy_i) begin
      tx_n++;
      tx_last = bus.tx_data_o;
    end
    pend      = bus.tx_vld_o && !bus.tx_rdy_i;
    pend_data = bus.tx_data_o;
    if (bus.reg_we_o) begin
      we_n++; we_cyc = cyc; we_addr = bus.reg_addr_o; we_data = bus.reg_wdata_o;
    end
    if (bus.reg_re_o) begin
      re_n++; re_cyc = cyc; re_addr = bus.reg_addr_o;
    end
  end

  int total = 0;
  int bad   = 0;
  int acc_cyc = 0;
  int err_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data_i = b;
    bus.rx_vld_i  = 1'b1;
    while (!bus.rx_rdy_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("rx_accept_wait", 32'(n), 32'(0));
    acc_cyc = cyc;
    tick();
    bus.rx_vld_i = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] x);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(x);
`else
    if (x == 8'h00 && x != 8'h00) send_byte(x);
`endif
  endtask

  task automatic wait_tx(input int base);
    int n = 0;
    while (tx_n == base && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("tx_wait", 32'(n), 32'(0));
    tick();
    tick();
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
    logic       we, re;
    logic [7:0] addr, wdata, tx;
    int         err_inc;
  } vec_t;

  vec_t vt [10];

  initial begin
    int we0, re0, tx0;
    vt[0] = '{3, 8'h57, 8'h10, 8'h77, 1'b1, 1'b0, 8'h10, 8'h77, 8'h4B, 0};
    vt[1] = '{2, 8'h52, 8'h10, 8'h00, 1'b0, 1'b1, 8'h10, 8'h00, 8'h77, 0};
    vt[2] = '{2, 8'h52, 8'h22, 8'h00, 1'b0, 1'b1, 8'h22, 8'h00, 8'h3C, 0};
    vt[3] = '{3, 8'h57, 8'hFF, 8'hC3, 1'b1, 1'b0, 8'hFF, 8'hC3, 8'h4B, 0};
    vt[4] = '{2, 8'h52, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hC3, 0};
    vt[5] = '{1, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 1};
    vt[6] = '{3, 8'h57, 8'h22, 8'h5A, 1'b1, 1'b0, 8'h22, 8'h5A, 8'h4B, 0};
    vt[7] = '{2, 8'h52, 8'h22, 8'h00, 1'b0, 1'b1, 8'h22, 8'h00, 8'h5A, 0};
    vt[8] = '{1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 1};
    vt[9] = '{2, 8'h52, 8'h33, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00, 8'h00, 0};

    rst = 1'b1;
    bus.rx_data_i = 8'h00;
    bus.rx_vld_i  = 1'b0;
    bus.tx_rdy_i  = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_rx_rdy", 32'(bus.rx_rdy_o), 32'd1);
    chk("rst_tx_vld", 32'(bus.tx_vld_o), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
    chk("rst_we", 32'(bus.reg_we_o), 32'd0);
    chk("rst_re", 32'(bus.reg_re_o), 32'd0);
    chk("rst_addr", 32'(bus.reg_addr_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Timeout: opcode then silence aborts after 16 idle cycles
    we0 = we_n; re0 = re_n; tx0 = tx_n;
    send_byte(8'h57);
    repeat (15) tick();
    chk("to_busy_last", 32'(busy), 32'd1);
    tick();
    chk("to_busy_after", 32'(busy), 32'd0);
    err_exp = 1;
    chk("to_err", 32'(err_cnt), 32'(err_exp));
    tick(); tick();
    chk("to_we", 32'(we_n - we0), 32'd0);
    chk("to_re", 32'(re_n - re0), 32'd0);
    chk("to_tx", 32'(tx_n - tx0), 32'd0);

    // A byte accepted in the timeout cycle is processed instead
    we0 = we_n; tx0 = tx_n;
    send_byte(8'h57);
    repeat (15) tick();
    send_byte(8'h10);
    send_byte(8'hA5);
    send_chk(8'hE2);
    wait_tx(tx0);
    chk("tob_we", 32'(we_n - we0), 32'd1);
    chk("tob_wdata", 32'(we_data), 32'hA5);
    chk("tob_tx", 32'(tx_last), 32'h4B);
    chk("tob_err", 32'(err_cnt), 32'(err_exp));

    // Table of single frames
    for (int i = 0; i < 10; i++) begin
      we0 = we_n; re0 = re_n; tx0 = tx_n;
      send_byte(vt[i].b0);
      if (vt[i].nb > 1) send_byte(vt[i].b1);
      if (vt[i].nb > 2) send_byte(vt[i].b2);
      if (vt[i].nb > 1) send_chk(vt[i].b0 ^ vt[i].b1 ^ ((vt[i].nb > 2) ? vt[i].b2 : 8'h00));
      wait_tx(tx0);
      err_exp += vt[i].err_inc;
      chk($sformatf("v%0d_tx_n", i), 32'(tx_n - tx0), 32'd1);
      chk($sformatf("v%0d_tx_data", i), 32'(tx_last), 32'(vt[i].tx));
      chk($sformatf("v%0d_we_n", i), 32'(we_n - we0), 32'(vt[i].we));
      chk($sformatf("v%0d_re_n", i), 32'(re_n - re0), 32'(vt[i].re));
      chk($sformatf("v%0d_err", i), 32'(err_cnt), 32'(err_exp));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      if (vt[i].we) begin
        chk($sformatf("v%0d_we_addr", i), 32'(we_addr), 32'(vt[i].addr));
        chk($sformatf("v%0d_we_data", i), 32'(we_data), 32'(vt[i].wdata));
        chk($sformatf("v%0d_we_lat", i), 32'(we_cyc - acc_cyc), 32'd1);
        chk($sformatf("v%0d_tx_lat", i), 32'(tx_first - acc_cyc), 32'd2);
      end else if (vt[i].re) begin
        chk($sformatf("v%0d_re_addr", i), 32'(re_addr), 32'(vt[i].addr));
        chk($sformatf("v%0d_re_lat", i), 32'(re_cyc - acc_cyc), 32'd1);
        chk($sformatf("v%0d_tx_lat", i), 32'(tx_first - acc_cyc), 32'd3);
      end else begin
        chk($sformatf("v%0d_tx_lat", i), 32'(tx_first - acc_cyc), 32'd1);
      end
    end

    // Bad opcode with the Tx side stalled for 5 cycles
    tx0 = tx_n;
    bus.tx_rdy_i = 1'b0;
    send_byte(8'h41);
    err_exp++;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_tx_vld", k), 32'(bus.tx_vld_o), 32'd1);
      chk($sformatf("bp%0d_tx_data", k), 32'(bus.tx_data_o), 32'h45);
      chk($sformatf("bp%0d_rx_rdy", k), 32'(bus.rx_rdy_o), 32'd0);
      tick();
    end
    chk("bp_err", 32'(err_cnt), 32'(err_exp));
    bus.tx_rdy_i = 1'b1;
    wait_tx(tx0);
    chk("bp_tx_n", 32'(tx_n - tx0), 32'd1);
    chk("bp_stable", 32'(stab_bad), 32'd0);

    // Reset in the middle of a write frame
    we0 = we_n; tx0 = tx_n;
    send_byte(8'h57);
    send_byte(8'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(err_cnt), 32'd0);
    chk("mr_rx_rdy", 32'(bus.rx_rdy_o), 32'd1);
    send_byte(8'hA5);
    wait_tx(tx0);
    chk("mr_tx", 32'(tx_last), 32'h45);
    chk("mr_we", 32'(we_n - we0), 32'd0);
    chk("mr_err2", 32'(err_cnt), 32'd1);

    // Error counter saturation: 300 bad opcodes in total
    for (int k = 0; k < 253; k++) send_byte(8'h41);
    repeat (5) tick();
    chk("sat_fe", 32'(err_cnt), 32'hFE);
    send_byte(8'h41);
    repeat (5) tick();
    chk("sat_ff", 32'(err_cnt), 32'hFF);
    for (int k = 0; k < 46; k++) send_byte(8'h41);
    repeat (5) tick();
    chk("sat_hold", 32'(err_cnt), 32'hFF);

`ifdef UART_CMD_CHKSUM_EN
    // Checksum match and mismatch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    we0 = we_n; tx0 = tx_n;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5); send_byte(8'hE2);
    wait_tx(tx0);
    chk("ck_ok_we", 32'(we_n - we0), 32'd1);
    chk("ck_ok_tx", 32'(tx_last), 32'h4B);
    we0 = we_n; tx0 = tx_n;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5); send_byte(8'hE3);
    wait_tx(tx0);
    chk("ck_bad_we", 32'(we_n - we0), 32'd0);
    chk("ck_bad_tx", 32'(tx_last), 32'h45);
    chk("ck_bad_err", 32'(err_cnt), 32'd1);
`endif

    chk("tx_stable_all", 32'(stab_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
